uart_hex_cmd_parser: RTL and testbench

//  Sequences ASCII characters from the UART RX byte stream through the ASCII-to-hex encoder.

---
 rtl/uart_hex_cmd_parser.sv | 175 +++++++++++++++++
 tb/tb_uart_hex_cmd_parser.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_cmd_parser.sv
// UART hex command parser: frames "W<addr><data>\r" / "R<addr>\r" byte streams
// into register-access commands issued on a valid/ready port.
module uart_hex_cmd_parser #(
    parameter int ADDR_DIGITS = 4,
    parameter int DATA_DIGITS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       rx_ready,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic                       cmd_write,
    output logic [4*ADDR_DIGITS-1:0]   cmd_addr,
    output logic [4*DATA_DIGITS-1:0]   cmd_wdata,
    output logic                       err
);
    localparam int AW = 4 * ADDR_DIGITS;
    localparam int DW = 4 * DATA_DIGITS;
    localparam int MAXD = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
    localparam int CW = $clog2(MAXD + 1);
    localparam logic [CW-1:0] LAST_A = CW'(ADDR_DIGITS - 1);
    localparam logic [CW-1:0] LAST_D = CW'(DATA_DIGITS - 1);

    localparam logic [7:0] CH_W  = 8'h57;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_TERM,
        S_ISSUE
    } state_t;

    state_t          state_q, state_d;
    logic            write_q, write_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            accept;
    logic            is_digit;
    logic [3:0]      nibble;

    ascii_hex_enc u_enc (
        .ascii_i  (rx_data),
        .nibble_o (nibble)
    );

    // Validity is decided here; the encoder's fallback value is never used.
    assign is_digit = ((rx_data >= 8'h30) && (rx_data <= 8'h39))
                   || ((rx_data >= 8'h41) && (rx_data <= 8'h46));

    assign rx_ready  = (state_q != S_ISSUE);
    assign accept    = rx_valid & rx_ready;
    assign cmd_valid = (state_q == S_ISSUE);
    assign cmd_write = write_q;
    assign cmd_addr  = addr_q;
    assign cmd_wdata = wdata_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if ((rx_data == CH_W) || (rx_data == CH_R)) begin
                        state_d = S_ADDR;
                        write_d = (rx_data == CH_W);
                        addr_d  = '0;
                        wdata_d = '0;
                        cnt_d   = '0;
                    end else if ((rx_data != CH_CR) && (rx_data != CH_LF)) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (accept) begin
                    if (!is_digit) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        addr_d = (addr_q << 4) | AW'(nibble);
                        if (cnt_q == LAST_A) begin
                            cnt_d   = '0;
                            state_d = write_q ? S_DATA : S_TERM;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (!is_digit) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        wdata_d = (wdata_q << 4) | DW'(nibble);
                        if (cnt_q == LAST_D) begin
                            cnt_d   = '0;
                            state_d = S_TERM;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            S_TERM: begin
                if (accept) begin
                    if (rx_data == CH_CR) begin
                        state_d = S_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// ASCII to nibble encoder; non-hex characters map to 0.
module ascii_hex_enc (
    input  logic [7:0] ascii_i,
    output logic [3:0] nibble_o
);
    always_comb begin
        nibble_o = 4'h0;
        if ((ascii_i >= 8'h30) && (ascii_i <= 8'h39)) begin
            nibble_o = ascii_i[3:0];
        end else if ((ascii_i >= 8'h41) && (ascii_i <= 8'h46)) begin
            nibble_o = ascii_i[3:0] + 4'd9;
        end
    end
endmodule

// File: tb/tb_uart_hex_cmd_parser.sv
// Bench for uart_hex_cmd_parser: table of command strings with expected
// commands/errors, plus hand sequences for back-pressure, reset and streaming.
module tb_uart_hex_cmd_parser;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        err;

    uart_hex_cmd_parser #(
        .ADDR_DIGITS (4),
        .DATA_DIGITS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    int          ncmd = 0;
    int          nerr = 0;
    logic        lw[64];
    logic [15:0] la[64];
    logic [7:0]  ld[64];

    // Transfers and err-high cycles are logged away from the clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (err) nerr++;
            if (cmd_valid && cmd_ready) begin
                if (ncmd < 64) begin
                    lw[ncmd] = cmd_write;
                    la[ncmd] = cmd_addr;
                    ld[ncmd] = cmd_wdata;
                end
                ncmd++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = rx_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            total++;
            $display("FAIL accept_timeout: byte %0h never accepted", b);
        end
    endtask

    task automatic send_txt(input logic [127:0] t);
        for (int k = 15; k >= 0; k--) begin
            if (t[8*k +: 8] != 8'h00) send_byte(t[8*k +: 8]);
        end
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [127:0] txt;
        int           ncmd;
        int           nerr;
        logic         w;
        logic [15:0]  a;
        logic [7:0]   d;
    } vec_t;

    localparam int NV = 12;
    vec_t vt[NV];

    int bc;
    int be;

    initial begin
        vt[0]  = '{"W12AB5C\r",   1, 0, 1'b1, 16'h12AB, 8'h5C};
        vt[1]  = '{"W1G",         0, 1, 1'b0, 16'h0000, 8'h00};
        vt[2]  = '{"R0001\r",     1, 0, 1'b0, 16'h0001, 8'h00};
        vt[3]  = '{"W12\r",       0, 1, 1'b0, 16'h0000, 8'h00};
        vt[4]  = '{"a",           0, 1, 1'b0, 16'h0000, 8'h00};
        vt[5]  = '{"W0001FFX",    0, 1, 1'b0, 16'h0000, 8'h00};
        vt[6]  = '{"\n\rR00FF\r", 1, 0, 1'b0, 16'h00FF, 8'h00};
        vt[7]  = '{"w1234\r",     0, 5, 1'b0, 16'h0000, 8'h00};
        vt[8]  = '{"RFFFF\r",     1, 0, 1'b0, 16'hFFFF, 8'h00};
        vt[9]  = '{"R00:",        0, 1, 1'b0, 16'h0000, 8'h00};
        vt[10] = '{"R@",          0, 1, 1'b0, 16'h0000, 8'h00};
        vt[11] = '{"WF0E1D2\r",   1, 0, 1'b1, 16'hF0E1, 8'hD2};

        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b1;
        do_reset();

        chk("rst_rx_ready", {31'b0, rx_ready}, 1);
        chk("rst_cmd_valid", {31'b0, cmd_valid}, 0);
        chk("rst_cmd_write", {31'b0, cmd_write}, 0);
        chk("rst_cmd_addr", {16'b0, cmd_addr}, 0);
        chk("rst_cmd_wdata", {24'b0, cmd_wdata}, 0);
        chk("rst_err", {31'b0, err}, 0);

        for (int i = 0; i < NV; i++) begin
            bc = ncmd;
            be = nerr;
            cmd_ready = 1'b1;
            send_txt(vt[i].txt);
            idle(4);
            chk($sformatf("v%0d_ncmd", i), ncmd - bc, vt[i].ncmd);
            chk($sformatf("v%0d_nerr", i), nerr - be, vt[i].nerr);
            if (vt[i].ncmd > 0 && ncmd > bc) begin
                chk($sformatf("v%0d_write", i), {31'b0, lw[bc]}, {31'b0, vt[i].w});
                chk($sformatf("v%0d_addr", i), {16'b0, la[bc]}, {16'b0, vt[i].a});
                chk($sformatf("v%0d_wdata", i), {24'b0, ld[bc]}, {24'b0, vt[i].d});
            end
        end

        // Back-pressured read held for five cycles.
        bc = ncmd;
        be = nerr;
        cmd_ready = 1'b0;
        send_txt("R00FF\r");
        chk("bp_latency_valid", {31'b0, cmd_valid}, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'b0, cmd_valid}, 1);
            chk("bp_hold_rx_ready", {31'b0, rx_ready}, 0);
            chk("bp_hold_addr", {16'b0, cmd_addr}, 32'h00FF);
            chk("bp_hold_wdata", {24'b0, cmd_wdata}, 0);
        end
        @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_after_valid", {31'b0, cmd_valid}, 0);
        chk("bp_after_rx_ready", {31'b0, rx_ready}, 1);
        chk("bp_ncmd", ncmd - bc, 1);
        chk("bp_write", {31'b0, lw[bc]}, 0);
        chk("bp_addr", {16'b0, la[bc]}, 32'h00FF);
        chk("bp_nerr", nerr - be, 0);

        // Reset mid-command, then a clean read.
        bc = ncmd;
        be = nerr;
        send_txt("W12A");
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_write", {31'b0, cmd_write}, 0);
        chk("mid_rst_addr", {16'b0, cmd_addr}, 0);
        chk("mid_rst_rx_ready", {31'b0, rx_ready}, 1);
        chk("mid_rst_err", {31'b0, err}, 0);
        send_txt("R1234\r");
        idle(3);
        chk("mid_rst_ncmd", ncmd - bc, 1);
        chk("mid_rst_cmd_addr", {16'b0, la[bc]}, 32'h1234);
        chk("mid_rst_cmd_wdata", {24'b0, ld[bc]}, 0);
        chk("mid_rst_cmd_write", {31'b0, lw[bc]}, 0);
        chk("mid_rst_nerr", nerr - be, 0);

        // Reset while issuing with the consumer stalled.
        bc = ncmd;
        be = nerr;
        cmd_ready = 1'b0;
        send_txt("R0001\r");
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("iss_rst_valid", {31'b0, cmd_valid}, 0);
        chk("iss_rst_rx_ready", {31'b0, rx_ready}, 1);
        chk("iss_rst_addr", {16'b0, cmd_addr}, 0);
        cmd_ready = 1'b1;
        idle(3);
        chk("iss_rst_ncmd", ncmd - bc, 0);
        chk("iss_rst_nerr", nerr - be, 0);

        // Two commands streamed with rx_valid held high.
        bc = ncmd;
        be = nerr;
        cmd_ready = 1'b1;
        send_txt("W0102FF\rR0A0B\r");
        idle(4);
        chk("str_ncmd", ncmd - bc, 2);
        chk("str_nerr", nerr - be, 0);
        chk("str0_write", {31'b0, lw[bc]}, 1);
        chk("str0_addr", {16'b0, la[bc]}, 32'h0102);
        chk("str0_wdata", {24'b0, ld[bc]}, 32'hFF);
        chk("str1_write", {31'b0, lw[bc+1]}, 0);
        chk("str1_addr", {16'b0, la[bc+1]}, 32'h0A0B);
        chk("str1_wdata", {24'b0, ld[bc+1]}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
